// File: rtl/canvas_painter.sv
// Rectangle-fill / clear write engine for the 200x150 canvas framebuffer.
// One clipped pixel write per cycle, row-major, after a single setup cycle.
module canvas_painter #(
  parameter int DW    = 15,
  parameter int H_LEN = 200,
  parameter int V_LEN = 150
)(
  input  logic          pclk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_clr,
  input  logic [7:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic [7:0]    cmd_w,
  input  logic [7:0]    cmd_h,
  input  logic [11:0]   cmd_color,
  output logic          we,
  output logic [DW-1:0] waddr,
  output logic [11:0]   wdata,
  output logic          busy,
  output logic          done
);

  localparam logic [8:0]    H9  = 9'(H_LEN);
  localparam logic [8:0]    V9  = 9'(V_LEN);
  localparam logic [DW-1:0] HDW = DW'(H_LEN);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
  state_t state, next_state;

  logic [7:0]    lx, ly, lw, lh;
  logic [11:0]   lcolor;
  logic [8:0]    x_sum, y_sum, x_end_c, y_end_c, x_end, y_end;
  logic [7:0]    col, row;
  logic [DW-1:0] row_base, base_c;
  logic          empty, last_col, last_row, accept;

  always_comb begin
    x_sum    = {1'b0, lx} + {1'b0, lw};
    y_sum    = {1'b0, ly} + {1'b0, lh};
    x_end_c  = (x_sum > H9) ? H9 : x_sum;
    y_end_c  = (y_sum > V9) ? V9 : y_sum;
    empty    = ({1'b0, lx} >= H9) || ({1'b0, ly} >= V9) || (lw == 8'd0) || (lh == 8'd0);
    base_c   = DW'(ly) * HDW;
    last_col = (({1'b0, col} + 9'd1) == x_end);
    last_row = (({1'b0, row} + 9'd1) == y_end);
    accept   = cmd_valid && cmd_ready;
  end

  always_ff @(posedge pclk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next_state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cmd_valid) next_state = SETUP;
      SETUP: next_state = empty ? DONE : FILL;
      FILL:  if (last_col && last_row) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == SETUP) || (state == FILL);
    done      = (state == DONE);
  end

  // Row turns advance row_base by H_LEN so FILL never needs a multiplier.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      lx <= '0; ly <= '0; lw <= '0; lh <= '0; lcolor <= '0;
      x_end <= '0; y_end <= '0; col <= '0; row <= '0; row_base <= '0;
      we <= 1'b0; waddr <= '0; wdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (cmd_clr) begin
            lx <= 8'd0; ly <= 8'd0; lw <= 8'(H_LEN); lh <= 8'(V_LEN);
          end else begin
            lx <= cmd_x; ly <= cmd_y; lw <= cmd_w; lh <= cmd_h;
          end
          lcolor <= cmd_color;
        end
        SETUP: begin
          x_end    <= x_end_c;
          y_end    <= y_end_c;
          col      <= lx;
          row      <= ly;
          row_base <= base_c;
          waddr    <= base_c + DW'(lx);
          wdata    <= lcolor;
          we       <= !empty;
        end
        FILL: begin
          if (last_col) begin
            if (last_row) we <= 1'b0;
            else begin
              col      <= lx;
              row      <= row + 8'd1;
              row_base <= row_base + HDW;
              waddr    <= row_base + HDW + DW'(lx);
            end
          end else begin
            col   <= col + 8'd1;
            waddr <= waddr + DW'(1);
          end
        end
        default: we <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/canvas_painter.md
# canvas_painter

Write-side engine for the 200×150 canvas framebuffer. Accepts rectangle-fill and full-clear commands over a valid/ready handshake, clips them to the canvas, and emits one 12-bit RGB pixel write per cycle in row-major order on the framebuffer write port. The display unit reads the same RAM through its own port and scales it 4× to the screen.

## Interface
- `DW`, 15, framebuffer address width; `H_LEN*V_LEN-1` must fit in `DW` bits.
- `H_LEN`, 200, canvas width in pixels (≤ 255).
- `V_LEN`, 150, canvas height in pixels (≤ 255).

Ports:
- `pclk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: asynchronous reset, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine can accept a command.
- `cmd_clr` in 1: 1 = clear the whole canvas; `cmd_x/y/w/h` are ignored.
- `cmd_x` in 8: rectangle left column.
- `cmd_y` in 8: rectangle top row.
- `cmd_w` in 8: rectangle width.
- `cmd_h` in 8: rectangle height.
- `cmd_color` in 12: RGB 4:4:4 fill value.
- `we` out 1: framebuffer write enable.
- `waddr` out DW: write address, `row*H_LEN + col`.
- `wdata` out 12: write data.
- `busy` out 1: command in progress (SETUP or FILL).
- `done` out 1: one-cycle pulse at command completion.

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE: `cmd_ready`=1, decoded combinationally from the state. Accept on `cmd_valid && cmd_ready`. Latch the command and go to SETUP.
- `cmd_clr`=1 is treated as x=0, y=0, w=H_LEN, h=V_LEN.
- SETUP (1 cycle, `busy`=1, `we`=0):
  - Compute 9-bit `x_end = min(x+w, H_LEN)` and `y_end = min(y+h, V_LEN)`.
  - Compute `row_base = y*H_LEN`, DW bits.
  - Load `col=x`, `row=y`.
  - If `x>=H_LEN`, `y>=V_LEN`, `w==0` or `h==0`, go to DONE with no writes. Otherwise go to FILL.
- FILL (`busy`=1, `we`=1): `waddr = row_base + col` and `wdata = color`, both registered.
  - Each cycle, `col` increments.
  - When `col+1 == x_end`, `col` returns to `x`, `row` increments and `row_base += H_LEN` (no multiplier in FILL).
  - After the write with `col == x_end-1` and `row == y_end-1`, go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0, `we`=0, `cmd_ready`=0. Then go to IDLE.
- Number of writes = `(x_end-x)*(y_end-y)`. Every address is in `[0, H_LEN*V_LEN-1]`. No address wrap is ever produced.
- `cmd_*` inputs are ignored outside IDLE. The latched command cannot change mid-fill.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0.
  - `cmd_ready`=1, both during reset and after release.
- Reset mid-FILL aborts at once: `we` drops asynchronously, no `done` pulse, no further writes.
- Accept at edge E0:
  - SETUP in cycle E0→E1.
  - First write visible E1→E2.
  - N writes occupy N consecutive cycles with no bubbles, including across row turns.
  - `done` occupies the cycle after the last write. `cmd_ready` returns the following cycle.
- Empty or off-canvas command: `done` in cycle E1→E2, `cmd_ready` back at E2.
- Back-to-back: minimum command spacing is N+3 cycles.
- `cmd_valid` held high while busy is not consumed. It is accepted on the first IDLE cycle.

## Test plan
- **Small rectangle.** Rect x=10, y=20, w=3, h=2, color 0xF00.
  - `we` for exactly 6 consecutive cycles.
  - `waddr` = 4010, 4011, 4012, 4210, 4211, 4212; `wdata`=0xF00 throughout.
  - `done` on the 7th cycle after SETUP.
- **Corner clip.** x=198, y=148, w=5, h=5, color 0x0A5.
  - 4 writes, to 29798, 29799, 29998, 29999.
  - No address ≥ 30000, then `done`.
- **Full clear.** `cmd_clr`=1, color 0x000, accepted at cycle 0.
  - `busy` in cycles 1–30001; writes in cycles 2–30001.
  - Addresses are 0..29999 strictly ascending; `done` in cycle 30002.
- **Degenerate commands.** Separately: w=0; x=200; y=150.
  - Zero writes in each case.
  - `done` 2 cycles after accept; `cmd_ready` back 3 cycles after accept.
- **Busy back-pressure.** Assert `cmd_valid` continuously with a second rect (0,0,1,1,0x123) during the first command.
  - `cmd_ready` stays 0 until the first command's `done` has passed.
  - Second command produces a single write to addr 0 with data 0x123.
- **Reset mid-fill.** Pulse `rst` for 1 cycle during the 3rd write of a 10×10 fill.
  - `we`=0 immediately; no `done`; `cmd_ready`=1.
  - A new 1×1 command after reset executes normally.
